// File: rtl/nand_gate_pkg.sv
// Shared defaults for the NAND leaf cell and its pipeline stage.
// Self-check option: define NAND_GATE_SELFCHECK_EN.
package nand_gate_pkg;
    localparam int DEF_WIDTH       = 1;
    localparam int DEF_PIPE_STAGES = 1;
    localparam int DEF_CNT_W       = 16;
    localparam int MAX_STAGES      = 4;
endpackage

// File: rtl/nand_gate_stage.sv
// One pipeline register stage: data loads only with a valid sample, so a bubble
// leaves the previous result in place; valid always advances.
module nand_gate_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            q_vld <= 1'b0;
        end else begin
            q_vld <= d_vld;
            if (d_vld) begin
                q <= d;
            end
        end
    end
endmodule

// File: rtl/nand_gate_unit.sv
// Bitwise NAND leaf cell with a registered/valid-tagged copy and a saturating
// sample counter. Optional shadow self-check: define NAND_GATE_SELFCHECK_EN.
module nand_gate_unit
    import nand_gate_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    input  logic             in_valid,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             chk_err
);
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] nand_p [PIPE_STAGES+1];
    logic [PIPE_STAGES:0] vld_p;

    assign c        = ~(a & b);
    assign nand_p[0] = c;
    assign vld_p[0]  = in_valid;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        nand_gate_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .d     (nand_p[g]),
            .d_vld (vld_p[g]),
            .q     (nand_p[g+1]),
            .q_vld (vld_p[g+1])
        );
    end

    assign c_q       = nand_p[PIPE_STAGES];
    assign out_valid = vld_p[PIPE_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt <= '0;
        end else if (in_valid) begin
            sample_cnt <= sat_inc(sample_cnt);
        end
    end

`ifdef NAND_GATE_SELFCHECK_EN
    // Shadow path uses De Morgan form so a fault in either path shows as a mismatch
    logic [WIDTH-1:0]     shd_p [PIPE_STAGES+1];
    logic [PIPE_STAGES:0] shd_vld_p;
    logic                 chk_err_r;

    assign shd_p[0]     = ~a | ~b;
    assign shd_vld_p[0] = in_valid;

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_shadow
        nand_gate_stage #(.WIDTH(WIDTH)) u_shadow (
            .clk   (clk),
            .rst   (rst),
            .d     (shd_p[g]),
            .d_vld (shd_vld_p[g]),
            .q     (shd_p[g+1]),
            .q_vld (shd_vld_p[g+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_r <= 1'b0;
        end else if (out_valid && shd_vld_p[PIPE_STAGES] && (c_q != shd_p[PIPE_STAGES])) begin
            chk_err_r <= 1'b1;
        end
    end

    assign chk_err = chk_err_r;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_nand_gate_unit.sv
// Randomized and directed bench for nand_gate_unit against a queue-based timing model.
module tb_nand_gate_unit;
    localparam int W   = 8;
    localparam int P   = 3;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b, c, c_q;
    logic          in_valid, out_valid, chk_err;
    logic [CW-1:0] sample_cnt;

    nand_gate_unit #(.WIDTH(W), .PIPE_STAGES(P), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .c          (c),
        .in_valid   (in_valid),
        .c_q        (c_q),
        .out_valid  (out_valid),
        .sample_cnt (sample_cnt),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: each accepted sample is scheduled to emerge at an absolute edge index
    typedef struct {
        int           due;
        logic [W-1:0] val;
    } ent_t;
    ent_t         pend[$];
    int           cyc  = 0;
    logic [W-1:0] cq_m = '0;
    logic         ov_m = 1'b0;
    int           cnt_m = 0;

    function automatic logic [W-1:0] ref_nand(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (x[i] && y[i]) ? 1'b0 : 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        ov_m = 1'b0;
        if (rst) begin
            pend.delete();
            cq_m  = '0;
            cnt_m = 0;
        end else begin
            if (in_valid) begin
                pend.push_back('{cyc + P - 1, ref_nand(a, b)});
                cnt_m = (cnt_m == CMAX) ? CMAX : cnt_m + 1;
            end
            if (pend.size() > 0 && pend[0].due == cyc) begin
                ov_m = 1'b1;
                cq_m = pend[0].val;
                void'(pend.pop_front());
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(ov_m));
        chk("c_q", 32'(c_q), 32'(cq_m));
        chk("sample_cnt", 32'(sample_cnt), 32'(cnt_m));
        chk("chk_err", 32'(chk_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] tt;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        // Truth table on bit 0, no edge needed; upper bits see a=b=0 so read 1
        tt = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            a = {7'd0, i[1]};
            b = {7'd0, i[0]};
            #10;
            chk("truth_table", 32'(c), 32'({7'h7F, tt[i]}));
        end

        step();
        rst = 1'b0;

        // Latency of a single pulse
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("lat_early1", 32'(out_valid), 32'd0);
        step();
        chk("lat_early2", 32'(out_valid), 32'd0);
        step();
        chk("lat_hit_ov", 32'(out_valid), 32'd1);
        chk("lat_hit_cq", 32'(c_q), 32'h00);
        step();
        chk("lat_one_cycle", 32'(out_valid), 32'd0);

        // Wide vector
        a = 8'hF0; b = 8'hAA; #1;
        chk("wide_c", 32'(c), 32'h5F);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        chk("wide_cq", 32'(c_q), 32'h5F);
        step();
        chk("wide_hold", 32'(c_q), 32'h5F);

        // Reset flushes in-flight samples
        a = 8'h0F; b = 8'h33; in_valid = 1'b1;
        repeat (2) step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) begin
            step();
            chk("flush_ov", 32'(out_valid), 32'd0);
        end
        chk("flush_cq", 32'(c_q), 32'h00);
        chk("flush_cnt", 32'(sample_cnt), 32'd0);

        // Reset wins over a simultaneous valid
        rst = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_vs_valid", 32'(sample_cnt), 32'd0);
        repeat (3) step();

        // Saturation
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom);
            step();
        end
        chk("sat_cnt", 32'(sample_cnt), 32'd15);
        in_valid = 1'b0;
        repeat (4) step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            in_valid = ($urandom_range(0, 99) < 60);
            rst      = ($urandom_range(0, 99) < 4);
            #1;
            chk("rand_c", 32'(c), 32'(ref_nand(a, b)));
            step();
        end
        rst = 1'b0; in_valid = 1'b0;

`ifdef NAND_GATE_SELFCHECK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        a = 8'hF0; b = 8'hAA; in_valid = 1'b1;
        repeat (3) step();
        force dut.c_q = 8'h5E;
        @(posedge clk); #1;
        release dut.c_q;
        in_valid = 1'b0;
        chk("selfchk_set", 32'(chk_err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("selfchk_sticky", 32'(chk_err), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("selfchk_clear", 32'(chk_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
